dmp_req_sequencer: RTL and testbench
====================================

// Module: dmp_req_sequencer
// PURPOSE
//  Shares the single DMP memory port between pipeline LD/ST and debug requesters.
//  Owns dmp_addr; the address decoder classifies it; this block routes one request to
//  the selected target (LD/ST RAM, code RAM, peripheral, LD/ST queue), waits, returns data.
//  Pipeline wins by default; a starvation counter bounds debug wait; a timeout bounds target wait.
// PARAMETERS
//  DBG_STARVE_MAX  4    pipe grants allowed while dbg_req pending before dbg is forced
//  TIMEOUT_CYCLES  255  max WAIT cycles before error completion (must be < 2**CNT_W)
//  CNT_W           8    width of timeout counter
// PORTS
//  clk            in   1   single clock
//  rst_a          in   1   reset, asynchronous, active-low
//  pipe_req       in   1   pipeline request; held until pipe_ack
//  pipe_addr      in   32  pipeline address
//  pipe_wr        in   1   1=store 0=load
//  pipe_wdata     in   32  store data
//  pipe_ack       out  1   1-cycle accept pulse
//  dbg_req/dbg_addr/dbg_wr/dbg_wdata  in  1/32/1/32  debug request, same rules
//  dbg_ack        out  1   1-cycle accept pulse
//  dmp_addr       out  32  registered address to decoder and targets
//  is_ldst_ram    in   1   decoder result
//  is_code_ram    in   1   decoder result
//  is_peripheral  in   1   decoder result
//  ifetch_busy    in   1   ifetch owns code RAM this cycle
//  tgt_req_ldst/tgt_req_code/tgt_req_per/tgt_req_q  out 1 each  1-cycle target strobe
//  tgt_wr         out  1   registered wr
//  tgt_wdata      out  32  registered store data
//  tgt_rvalid     in   1   selected target done (externally muxed)
//  tgt_rdata      in   32  load data
//  rsp_valid      out  1   1-cycle completion pulse
//  rsp_owner      out  1   0=pipe 1=dbg
//  rsp_err        out  1   completion by timeout
//  rsp_rdata      out  32  load data (0 on store or err)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-transaction: abandoned; no rsp.
//  FSM: IDLE->DECODE->ISSUE->WAIT->IDLE.
//  IDLE cycle N with req: pick winner; latch addr/wr/wdata; winner ack=1 in N+1; state DECODE.
//  DECODE N+1: dmp_addr valid; register target sel, priority ldst>code>per>queue (if none: queue).
//  ISSUE N+2: one tgt_req_* pulse -> WAIT. If sel=code and ifetch_busy: hold ISSUE, no strobe.
//  WAIT: tgt_rvalid in cycle M -> rsp_valid, rsp_rdata=tgt_rdata (0 if wr), err=0 at M+1; IDLE.
//  Min latency req->rsp_valid = 4 cycles (tgt_rvalid same cycle as strobe+1).
//  Timeout: cnt clears entering WAIT, +1 per WAIT cycle; cnt==TIMEOUT_CYCLES and no rvalid ->
//   rsp_valid=1, rsp_err=1, rdata=0; late tgt_rvalid in IDLE ignored.
//  rvalid on final timeout cycle wins (err=0).
//  IDLE is re-entered in the rsp_valid cycle and may accept a new request that cycle.
//  Arbitration: both req -> pipe unless starve==DBG_STARVE_MAX, then dbg. starve +1 per pipe
//   grant with dbg_req high, saturates; clears on dbg grant or dbg_req low in IDLE.
//  ISSUE wait on ifetch_busy unbounded (ifetch guarantees release); no timeout counting in ISSUE.
//  dmp_addr, tgt_wr, tgt_wdata hold from DECODE until next grant.
// STRUCTURE
//  Shared include dmp_seq_defs.v: state encodings (2b), target codes TGT_LDST/CODE/PER/Q, owner codes.
//  Sub-module dmp_seq_arb: combinational winner pick + starvation counter register.
//  Decoder instantiated by parent on dmp_addr; not inside this block.
// TESTING
//  pipe load 0x8000_0040 in ldst range, rvalid 1 cycle after strobe, rdata=0xDEAD_BEEF ->
//   tgt_req_ldst at N+2, rsp_valid N+4, owner=0, rdata=0xDEAD_BEEF.
//  pipe+dbg held continuously, DBG_STARVE_MAX=4 -> grant order P,P,P,P,D,P...; no double ack.
//  code RAM addr with ifetch_busy high 6 cycles -> strobe delayed exactly 6 cycles, single pulse.
//  target never responds, TIMEOUT_CYCLES=255 -> rsp_err=1, rdata=0; rvalid next cycle ignored.
//  rst_a low during WAIT -> outputs 0 immediately; after release new pipe req completes normally.
//  is_ldst_ram and is_code_ram both 1 -> only tgt_req_ldst; none set -> tgt_req_q.

Source files
------------

// File: rtl/dmp_req_sequencer_pkg.sv
// Shared encodings for the DMP request sequencer: FSM states, target and owner codes,
// the latched request record and the target-priority helper.
package dmp_req_sequencer_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  localparam logic [1:0] TGT_LDST = 2'd0;
  localparam logic [1:0] TGT_CODE = 2'd1;
  localparam logic [1:0] TGT_PER  = 2'd2;
  localparam logic [1:0] TGT_Q    = 2'd3;

  localparam logic OWN_PIPE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } dmp_req_t;

  // Overlapping decoder hits resolve ldst > code > per; no hit falls through to the queue.
  function automatic logic [1:0] tgt_sel(input logic ldst, input logic code, input logic per);
    logic [1:0] sel;
    if (ldst)      sel = TGT_LDST;
    else if (code) sel = TGT_CODE;
    else if (per)  sel = TGT_PER;
    else           sel = TGT_Q;
    return sel;
  endfunction

endpackage

// File: rtl/dmp_req_sequencer_arb.sv
// Pipe-vs-debug winner pick for the DMP port. Pipe wins unless debug has already been
// passed over DBG_STARVE_MAX times while waiting.
module dmp_req_sequencer_arb #(
  parameter int DBG_STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_a,
  input  logic en,
  input  logic pipe_req,
  input  logic dbg_req,
  output logic grant_pipe,
  output logic grant_dbg
);

  localparam int STV_W = $clog2(DBG_STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(DBG_STARVE_MAX);

  logic [STV_W-1:0] starve;
  logic             force_dbg;

  assign force_dbg = (starve == STV_MAX);

  always_comb begin
    grant_pipe = en && pipe_req && !(dbg_req && force_dbg);
    grant_dbg  = en && dbg_req && (!pipe_req || force_dbg);
  end

  // Only IDLE cycles count; the counter saturates at the force threshold.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      starve <= '0;
    end else if (en) begin
      if (grant_dbg || !dbg_req)       starve <= '0;
      else if (grant_pipe && !force_dbg) starve <= starve + 1'b1;
    end
  end

endmodule

// File: rtl/dmp_req_sequencer.sv
// Routes one pipe or debug request at a time over the single DMP port to the decoded
// target, waits for completion or timeout, and returns a one-cycle response.
module dmp_req_sequencer
  import dmp_req_sequencer_pkg::*;
#(
  parameter int DBG_STARVE_MAX = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_a,
  input  logic        pipe_req,
  input  logic [31:0] pipe_addr,
  input  logic        pipe_wr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_ack,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  input  logic        dbg_wr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dmp_addr,
  input  logic        is_ldst_ram,
  input  logic        is_code_ram,
  input  logic        is_peripheral,
  input  logic        ifetch_busy,
  output logic        tgt_req_ldst,
  output logic        tgt_req_code,
  output logic        tgt_req_per,
  output logic        tgt_req_q,
  output logic        tgt_wr,
  output logic [31:0] tgt_wdata,
  input  logic        tgt_rvalid,
  input  logic [31:0] tgt_rdata,
  output logic        rsp_valid,
  output logic        rsp_owner,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state;
  logic [1:0]       sel;
  logic             own;
  logic [CNT_W-1:0] cnt;
  dmp_req_t         cur;
  dmp_req_t         pipe_rq;
  dmp_req_t         dbg_rq;
  logic             grant_pipe;
  logic             grant_dbg;
  logic             issue_hold;
  logic             strobe;
  logic             done_ok;
  logic             done_to;

  assign pipe_rq = '{addr: pipe_addr, wr: pipe_wr, wdata: pipe_wdata};
  assign dbg_rq  = '{addr: dbg_addr,  wr: dbg_wr,  wdata: dbg_wdata};

  dmp_req_sequencer_arb #(
    .DBG_STARVE_MAX(DBG_STARVE_MAX)
  ) u_arb (
    .clk       (clk),
    .rst_a     (rst_a),
    .en        (state == S_IDLE),
    .pipe_req  (pipe_req),
    .dbg_req   (dbg_req),
    .grant_pipe(grant_pipe),
    .grant_dbg (grant_dbg)
  );

  // Code RAM belongs to ifetch while it is busy; the strobe simply waits in ISSUE.
  assign issue_hold = (sel == TGT_CODE) && ifetch_busy;
  assign strobe     = (state == S_ISSUE) && !issue_hold;
  assign done_ok    = (state == S_WAIT) && tgt_rvalid;
  assign done_to    = (state == S_WAIT) && !tgt_rvalid && (cnt == TMO);

  assign tgt_req_ldst = strobe && (sel == TGT_LDST);
  assign tgt_req_code = strobe && (sel == TGT_CODE);
  assign tgt_req_per  = strobe && (sel == TGT_PER);
  assign tgt_req_q    = strobe && (sel == TGT_Q);

  assign dmp_addr  = cur.addr;
  assign tgt_wr    = cur.wr;
  assign tgt_wdata = cur.wdata;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state     <= S_IDLE;
      sel       <= TGT_LDST;
      own       <= OWN_PIPE;
      cnt       <= '0;
      cur       <= '0;
      pipe_ack  <= 1'b0;
      dbg_ack   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_owner <= OWN_PIPE;
      rsp_rdata <= '0;
    end else begin
      pipe_ack  <= grant_pipe;
      dbg_ack   <= grant_dbg;
      rsp_valid <= done_ok || done_to;
      rsp_err   <= done_to;
      rsp_owner <= (done_ok || done_to) ? own : OWN_PIPE;
      rsp_rdata <= (done_ok && !cur.wr) ? tgt_rdata : '0;
      case (state)
        S_IDLE: begin
          if (grant_pipe || grant_dbg) begin
            cur   <= grant_dbg ? dbg_rq : pipe_rq;
            own   <= grant_dbg ? OWN_DBG : OWN_PIPE;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          sel   <= tgt_sel(is_ldst_ram, is_code_ram, is_peripheral);
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!issue_hold) begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done_ok || done_to) state <= S_IDLE;
          else                    cnt   <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmp_req_sequencer.sv
// Directed bench for dmp_req_sequencer: latency, arbitration fairness, ifetch stall,
// target priority, timeout boundary and mid-transaction reset.
module tb_dmp_req_sequencer;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        pipe_req = 1'b0, pipe_wr = 1'b0, pipe_ack;
  logic [31:0] pipe_addr = '0, pipe_wdata = '0;
  logic        dbg_req = 1'b0, dbg_wr = 1'b0, dbg_ack;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] dmp_addr;
  logic        is_ldst_ram = 1'b0, is_code_ram = 1'b0, is_peripheral = 1'b0, ifetch_busy = 1'b0;
  logic        tgt_req_ldst, tgt_req_code, tgt_req_per, tgt_req_q, tgt_wr;
  logic [31:0] tgt_wdata;
  logic        tgt_rvalid = 1'b0;
  logic [31:0] tgt_rdata = '0;
  logic        rsp_valid, rsp_owner, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  dmp_req_sequencer dut (
    .clk(clk), .rst_a(rst_a),
    .pipe_req(pipe_req), .pipe_addr(pipe_addr), .pipe_wr(pipe_wr), .pipe_wdata(pipe_wdata),
    .pipe_ack(pipe_ack),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wr(dbg_wr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack),
    .dmp_addr(dmp_addr),
    .is_ldst_ram(is_ldst_ram), .is_code_ram(is_code_ram), .is_peripheral(is_peripheral),
    .ifetch_busy(ifetch_busy),
    .tgt_req_ldst(tgt_req_ldst), .tgt_req_code(tgt_req_code), .tgt_req_per(tgt_req_per),
    .tgt_req_q(tgt_req_q), .tgt_wr(tgt_wr), .tgt_wdata(tgt_wdata),
    .tgt_rvalid(tgt_rvalid), .tgt_rdata(tgt_rdata),
    .rsp_valid(rsp_valid), .rsp_owner(rsp_owner), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strb();
    return {tgt_req_ldst, tgt_req_code, tgt_req_per, tgt_req_q};
  endfunction

  // Pipe transaction with target answering one cycle after the strobe.
  task automatic txn(input string tag, input logic [31:0] addr, input logic wr,
                     input logic [31:0] wdata, input logic ld, input logic cd, input logic pr,
                     input logic [3:0] exp_strb, input logic [31:0] rdata);
    is_ldst_ram = ld; is_code_ram = cd; is_peripheral = pr;
    pipe_addr = addr; pipe_wr = wr; pipe_wdata = wdata; tgt_rdata = rdata;
    pipe_req = 1'b1;
    tick();
    chk({tag, ".ack"}, {dbg_ack, pipe_ack}, 32'd1);
    chk({tag, ".addr"}, dmp_addr, addr);
    chk({tag, ".wr"}, tgt_wr, wr);
    chk({tag, ".wdata"}, tgt_wdata, wdata);
    pipe_req = 1'b0;
    tick();
    chk({tag, ".strobe"}, strb(), exp_strb);
    tick();
    chk({tag, ".strobe_once"}, strb(), 32'd0);
    tgt_rvalid = 1'b1;
    tick();
    tgt_rvalid = 1'b0;
    chk({tag, ".rsp"}, {rsp_valid, rsp_err, rsp_owner}, 32'b100);
    chk({tag, ".rdata"}, rsp_rdata, wr ? 32'd0 : rdata);
    tick();
    chk({tag, ".rsp_once"}, rsp_valid, 32'd0);
  endtask

  initial begin
    logic [5:0] exp_dbg;
    logic       got;
    int         cyc, last, lat;

    // reset state
    tick(); tick();
    chk("rst.ack", {pipe_ack, dbg_ack}, 32'd0);
    chk("rst.addr", dmp_addr, 32'd0);
    chk("rst.wr", tgt_wr, 32'd0);
    chk("rst.wdata", tgt_wdata, 32'd0);
    chk("rst.strobe", strb(), 32'd0);
    chk("rst.rsp", {rsp_valid, rsp_err, rsp_owner}, 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    rst_a = 1'b1;
    tick();

    // basic load: strobe N+2, rsp N+4
    txn("ld", 32'h8000_0040, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 4'b1000, 32'hDEAD_BEEF);
    // store returns zero data even if target drives rdata
    txn("st", 32'h8000_0080, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h1111_2222);
    // target priority
    txn("pri.ld_cd", 32'h0000_0100, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 4'b1000, 32'h0000_0001);
    txn("pri.none", 32'h4000_0000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 32'h0000_0002);
    txn("pri.per", 32'hF000_0000, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h0000_0003);
    txn("pri.cd_per", 32'h0000_2000, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 4'b0100, 32'h0000_0004);

    // arbitration: both held, target always ready -> P,P,P,P,D,P at 4-cycle spacing
    is_ldst_ram = 1'b1; is_code_ram = 1'b0; is_peripheral = 1'b0;
    pipe_addr = 32'h8000_0400; pipe_wr = 1'b0;
    dbg_addr = 32'h8000_0800; dbg_wr = 1'b0;
    tgt_rvalid = 1'b1;
    pipe_req = 1'b1; dbg_req = 1'b1;
    exp_dbg = 6'b01_0000;
    cyc = 0; last = 0;
    for (int g = 0; g < 6; g++) begin
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        tick(); cyc++;
        if (pipe_ack || dbg_ack) got = 1'b1;
      end
      chk($sformatf("arb.seen%0d", g), got, 32'd1);
      chk($sformatf("arb.double%0d", g), pipe_ack && dbg_ack, 32'd0);
      chk($sformatf("arb.who%0d", g), dbg_ack, exp_dbg[g]);
      chk($sformatf("arb.addr%0d", g), dmp_addr, exp_dbg[g] ? dbg_addr : pipe_addr);
      if (g > 0) chk($sformatf("arb.gap%0d", g), cyc - last, 32'd4);
      last = cyc;
    end
    pipe_req = 1'b0; dbg_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (rsp_valid) got = 1'b1;
    end
    chk("arb.drain", {got, rsp_owner}, 32'b10);
    tgt_rvalid = 1'b0;
    tick();

    // ifetch holds code RAM for 6 cycles -> strobe at N+8
    is_ldst_ram = 1'b0; is_code_ram = 1'b1; ifetch_busy = 1'b1;
    pipe_addr = 32'h0000_1000; pipe_req = 1'b1;
    tick();
    chk("ifb.ack", pipe_ack, 32'd1);
    pipe_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("ifb.hold%0d", k), strb(), 32'd0);
    end
    tick();
    ifetch_busy = 1'b0;
    #1;
    chk("ifb.strobe", strb(), 32'b0100);
    tick();
    chk("ifb.once", strb(), 32'd0);
    tgt_rvalid = 1'b1; tgt_rdata = 32'h0BAD_C0DE;
    tick();
    tgt_rvalid = 1'b0;
    chk("ifb.rsp", {rsp_valid, rsp_err}, 32'b10);
    chk("ifb.rdata", rsp_rdata, 32'h0BAD_C0DE);
    tick();

    // timeout: strobe at S, WAIT cnt 0..255 over S+1..S+256, error rsp at S+257
    is_code_ram = 1'b0; is_ldst_ram = 1'b1;
    pipe_addr = 32'h8000_0100; pipe_wr = 1'b0; tgt_rdata = 32'h1234_5678;
    pipe_req = 1'b1;
    tick(); pipe_req = 1'b0;
    tick();
    chk("tmo.strobe", strb(), 32'b1000);
    got = 1'b0; lat = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick(); lat++;
      if (rsp_valid) got = 1'b1;
    end
    chk("tmo.seen", got, 32'd1);
    chk("tmo.lat", lat, 32'd257);
    chk("tmo.err", rsp_err, 32'd1);
    chk("tmo.rdata", rsp_rdata, 32'd0);
    tick();
    tgt_rvalid = 1'b1;
    tick();
    tgt_rvalid = 1'b0;
    chk("tmo.late_ignored", rsp_valid, 32'd0);

    // rvalid on the final timeout cycle completes normally
    pipe_req = 1'b1;
    tick(); pipe_req = 1'b0;
    tick();
    chk("tmo_last.strobe", strb(), 32'b1000);
    repeat (256) tick();
    chk("tmo_last.pre", rsp_valid, 32'd0);
    tgt_rvalid = 1'b1;
    tick();
    tgt_rvalid = 1'b0;
    chk("tmo_last.rsp", {rsp_valid, rsp_err}, 32'b10);
    chk("tmo_last.rdata", rsp_rdata, 32'h1234_5678);
    tick();

    // reset during WAIT: abandoned, outputs clear immediately
    pipe_addr = 32'h8000_0200; pipe_wr = 1'b1; pipe_wdata = 32'hA5A5_5A5A;
    pipe_req = 1'b1;
    tick(); pipe_req = 1'b0;
    tick(); tick();
    chk("rstw.pre", dmp_addr, 32'h8000_0200);
    rst_a = 1'b0;
    #1;
    chk("rstw.addr", dmp_addr, 32'd0);
    chk("rstw.wr", {tgt_wr, strb()}, 32'd0);
    chk("rstw.wdata", tgt_wdata, 32'd0);
    chk("rstw.rsp", {rsp_valid, rsp_err}, 32'd0);
    tgt_rvalid = 1'b1;
    tick(); tick();
    rst_a = 1'b1;
    tick(); tick();
    chk("rstw.no_rsp", rsp_valid, 32'd0);
    tgt_rvalid = 1'b0;
    txn("post_rst", 32'h8000_0040, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h5555_AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
